// File: rtl/encoded_event_decoder_pkg.sv
// Shared types and sizing helpers for the encoded event decoder.
// Pulse counter holds PULSE_CYCLES-1, so $clog2(PULSE_CYCLES) bits suffice (never fewer than 1).
package encoded_event_decoder_pkg;

  typedef enum logic [0:0] {StIdle, StPulse} state_t;

  localparam int unsigned MaxPulseCycles = 16;

  function automatic int unsigned cnt_width(int unsigned pulse_cycles);
    return (pulse_cycles > 1) ? $clog2(pulse_cycles) : 1;
  endfunction

endpackage

// File: rtl/pending_flag_bank.sv
// Per-channel sticky pending and overflow flags fed by the decoder's accepted-event vector.
module pending_flag_bank
  import encoded_event_decoder_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_OUTPUTS-1:0] set_vec,
  input  logic [NUM_OUTPUTS-1:0] ack,
  input  logic                   err_clear,
  output logic [NUM_OUTPUTS-1:0] pending,
  output logic [NUM_OUTPUTS-1:0] overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      // A new event beats a same-cycle ack; an ack alongside the event excuses the overflow.
      pending  <= set_vec | (pending & ~ack);
      overflow <= (err_clear ? '0 : overflow) | (set_vec & pending & ~ack);
    end
  end

endmodule

// File: rtl/encoded_event_decoder.sv
// Binary index to one-hot pulse decoder with valid/ready intake and sticky per-channel flags.
// The FSM, pulse counter, index decode and err_index live here; flags live in the bank.
module encoded_event_decoder
  import encoded_event_decoder_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS  = 8,
  parameter int unsigned IDX_W        = $clog2(NUM_OUTPUTS),
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_index,
  output logic [NUM_OUTPUTS-1:0] out_onehot,
  output logic                   out_valid,
  output logic [NUM_OUTPUTS-1:0] pending,
  input  logic [NUM_OUTPUTS-1:0] ack,
  output logic [NUM_OUTPUTS-1:0] overflow,
  output logic                   err_index,
  input  logic                   err_clear
);

  localparam int unsigned CntW = cnt_width(PULSE_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_CYCLES - 1);

  state_t                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   live_q;
  logic                   accept;
  logic                   in_range;
  logic [NUM_OUTPUTS-1:0] set_vec;

  // live_q keeps in_ready low until the first edge after reset is released.
  assign in_ready = live_q && (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  if (NUM_OUTPUTS < (2 ** IDX_W)) begin : g_range_chk
    assign in_range = (32'(in_index) < NUM_OUTPUTS);
  end else begin : g_range_full
    assign in_range = 1'b1;
  end

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
      set_vec[i] = accept && in_range && (in_index == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      live_q     <= 1'b0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (accept && in_range) begin
            out_onehot <= set_vec;
            out_valid  <= 1'b1;
            cnt_q      <= CntLoad;
            state_q    <= StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_index <= 1'b0;
    end else if (accept && !in_range) begin
      err_index <= 1'b1;
    end else if (err_clear) begin
      err_index <= 1'b0;
    end
  end

  pending_flag_bank #(
    .NUM_OUTPUTS(NUM_OUTPUTS)
  ) u_flags (
    .clk      (clk),
    .rst      (rst),
    .set_vec  (set_vec),
    .ack      (ack),
    .err_clear(err_clear),
    .pending  (pending),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_encoded_event_decoder.sv
// Drives three decoder configurations (8/1, 8/3, 6/4) with shared stimulus against a cycle model.
module tb_encoded_event_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       err_clear = 1'b0;
  logic [2:0] in_index = '0;
  logic [7:0] ack = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Per-DUT observation vector: {ready, valid, err, onehot[7:0], pending[7:0], overflow[7:0]}
  logic [26:0] d_vec [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NO = (g == 2) ? 6 : 8;
    localparam int unsigned PC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic          rdy, vld, err;
    logic [NO-1:0] oh, pe, ov;
    encoded_event_decoder #(
      .NUM_OUTPUTS (NO),
      .PULSE_CYCLES(PC)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .in_index  (in_index),
      .out_onehot(oh),
      .out_valid (vld),
      .pending   (pe),
      .ack       (ack[NO-1:0]),
      .overflow  (ov),
      .err_index (err),
      .err_clear (err_clear)
    );
    assign d_vec[g] = {rdy, vld, err, 8'(oh), 8'(pe), 8'(ov)};
  end

  // Reference model: remaining pulse cycles and the channel being pulsed, plus flag words.
  int         m_rem   [3];
  int         m_chan  [3];
  logic [7:0] m_pend  [3];
  logic [7:0] m_ovf   [3];
  logic       m_err   [3];
  logic       m_alive [3];

  function automatic int n_of(int k);
    return (k == 2) ? 6 : 8;
  endfunction

  function automatic int p_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic m_ready(int k);
    return m_alive[k] && (m_rem[k] == 0);
  endfunction

  function automatic logic [26:0] m_vec(int k);
    logic [7:0] oh;
    oh = (m_rem[k] > 0) ? (8'(1) << m_chan[k]) : 8'h00;
    return {m_ready(k), (m_rem[k] > 0), m_err[k], oh, m_pend[k], m_ovf[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_chan[k] = 0; m_pend[k] = '0; m_ovf[k] = '0;
      m_err[k] = 1'b0; m_alive[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      logic       acc, inr;
      logic [7:0] setb, ovb;
      acc  = in_valid && m_ready(k);
      inr  = int'(in_index) < n_of(k);
      setb = (acc && inr) ? (8'(1) << in_index) : 8'h00;
      ovb  = setb & m_pend[k] & ~ack;
      m_pend[k] = (m_pend[k] & ~ack) | setb;
      m_ovf[k]  = (err_clear ? 8'h00 : m_ovf[k]) | ovb;
      m_err[k]  = (acc && !inr) || (m_err[k] && !err_clear);
      if (acc && inr) begin
        m_rem[k]  = p_of(k);
        m_chan[k] = int'(in_index);
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
      end
      m_alive[k] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    in_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic fire(input logic [2:0] idx, input logic [7:0] a, input logic ec);
    in_index = idx; in_valid = 1'b1; ack = a; err_clear = ec;
    tick();
    in_valid = 1'b0; ack = '0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k] !== 27'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h expected %h", k, d_vec[k], 27'h0);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][26] !== 1'b0) begin
        errors++;
        $display("FAIL ready_before_edge dut%0d: got %b expected 0", k, d_vec[k][26]);
      end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][26] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_edge dut%0d: got %b expected 1", k, d_vec[k][26]);
      end
    end
  endtask

  task automatic test_single();
    fire(3'd5, 8'h00, 1'b0);
    checks++;
    if (d_vec[0] !== {1'b0, 1'b1, 1'b0, 8'h20, 8'h20, 8'h00}) begin
      errors++;
      $display("FAIL single_pulse: got %h expected %h", d_vec[0],
               {1'b0, 1'b1, 1'b0, 8'h20, 8'h20, 8'h00});
    end
    tick();
    checks++;
    if (d_vec[0] !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 8'h00}) begin
      errors++;
      $display("FAIL single_end: got %h expected %h", d_vec[0],
               {1'b1, 1'b0, 1'b0, 8'h00, 8'h20, 8'h00});
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (d_vec[k] !== m_vec(k)) begin
        errors++;
        $display("FAIL single_model dut%0d: got %h expected %h", k, d_vec[k], m_vec(k));
      end
    end
    ack = 8'hFF; tick(); ack = '0;
  endtask

  task automatic test_back_to_back();
    int   i = 0;
    int   cyc = 0;
    logic rdy;
    wait_idle();
    in_valid = 1'b1;
    while (i < 8 && cyc < 40) begin
      in_index = 3'(i);
      rdy = m_ready(0);
      checks++;
      if (d_vec[0][26] !== rdy) begin
        errors++;
        $display("FAIL sweep_ready cyc%0d: got %b expected %b", cyc, d_vec[0][26], rdy);
      end
      tick();
      cyc++;
      if (rdy) begin
        checks++;
        if (d_vec[0][23:16] !== (8'(1) << i)) begin
          errors++;
          $display("FAIL sweep_onehot idx%0d: got %h expected %h", i, d_vec[0][23:16],
                   8'(1) << i);
        end
        i++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cyc != 15) begin
      errors++;
      $display("FAIL sweep_cycles: got %0d expected 15", cyc);
    end
    tick();
    checks++;
    if (d_vec[0][15:0] !== 16'hFF00) begin
      errors++;
      $display("FAIL sweep_flags: got %h expected ff00", d_vec[0][15:0]);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (d_vec[k] !== m_vec(k)) begin
        errors++;
        $display("FAIL sweep_model dut%0d: got %h expected %h", k, d_vec[k], m_vec(k));
      end
    end
  endtask

  task automatic test_pulse_width();
    int hi [3];
    int lo [3];
    wait_idle();
    ack = 8'hFF; err_clear = 1'b1; tick(); ack = '0; err_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin hi[k] = 0; lo[k] = 0; end
    fire(3'd2, 8'h00, 1'b0);
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < 3; k++) begin
        hi[k] += (d_vec[k][23:16] == 8'h04) ? 1 : 0;
        lo[k] += (d_vec[k][26] == 1'b0) ? 1 : 0;
      end
      if (s < 5) tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (hi[k] != p_of(k) || lo[k] != p_of(k)) begin
        errors++;
        $display("FAIL pulse_width dut%0d: got high=%0d busy=%0d expected %0d", k, hi[k], lo[k],
                 p_of(k));
      end
    end
  endtask

  task automatic test_overflow();
    wait_idle();
    ack = 8'hFF; err_clear = 1'b1; tick(); ack = '0; err_clear = 1'b0;
    fire(3'd3, 8'h00, 1'b0);
    wait_idle();
    fire(3'd3, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][11] !== 1'b1 || d_vec[k][3] !== 1'b1) begin
        errors++;
        $display("FAIL overflow_set dut%0d: got pend=%h ovf=%h expected bit3 both", k,
                 d_vec[k][15:8], d_vec[k][7:0]);
      end
    end
    wait_idle();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][7:0] !== 8'h00 || d_vec[k][24] !== 1'b0) begin
        errors++;
        $display("FAIL err_clear dut%0d: got ovf=%h err=%b expected 00 0", k, d_vec[k][7:0],
                 d_vec[k][24]);
      end
    end
    fire(3'd3, 8'h08, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][11] !== 1'b1 || d_vec[k][3] !== 1'b0) begin
        errors++;
        $display("FAIL ack_same_cycle dut%0d: got pend=%h ovf=%h expected pend3=1 ovf3=0", k,
                 d_vec[k][15:8], d_vec[k][7:0]);
      end
    end
    wait_idle();
    fire(3'd3, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][3] !== 1'b1) begin
        errors++;
        $display("FAIL clear_vs_set dut%0d: got ovf=%h expected bit3 set", k, d_vec[k][7:0]);
      end
    end
  endtask

  task automatic test_out_of_range();
    wait_idle();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    fire(3'd7, 8'h00, 1'b0);
    checks++;
    if (d_vec[2][26:16] !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL out_of_range: got rdy/vld/err/oh=%h expected %h", d_vec[2][26:16],
               {1'b1, 1'b0, 1'b1, 8'h00});
    end
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_index = (c == 1) ? 3'd7 : 3'd6;
      tick();
      checks++;
      if (d_vec[2][26] !== 1'b1 || d_vec[2][23:16] !== 8'h00) begin
        errors++;
        $display("FAIL oor_stream c%0d: got rdy=%b oh=%h expected 1 00", c, d_vec[2][26],
                 d_vec[2][23:16]);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k] !== m_vec(k)) begin
        errors++;
        $display("FAIL oor_model dut%0d: got %h expected %h", k, d_vec[k], m_vec(k));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_index  = 3'($urandom_range(0, 7));
      ack       = 8'($urandom & $urandom & $urandom);
      err_clear = ($urandom_range(0, 7) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_vec[k] !== m_vec(k)) begin
          errors++;
          $display("FAIL random c%0d dut%0d: got %h expected %h", c, k, d_vec[k], m_vec(k));
        end
      end
    end
    in_valid = 1'b0; ack = '0; err_clear = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    wait_idle();
    fire(3'd1, 8'h00, 1'b0);
    wait_idle();
    fire(3'd1, 8'h00, 1'b0);
    tick();
    checks++;
    if (d_vec[2][23:16] !== 8'h02 || d_vec[2][1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got oh=%h ovf=%h expected 02 with bit1", d_vec[2][23:16],
               d_vec[2][7:0]);
    end
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k] !== 27'h0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h expected %h", k, d_vec[k], 27'h0);
      end
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k][26] !== 1'b0) begin
        errors++;
        $display("FAIL ready_held dut%0d: got %b expected 0", k, d_vec[k][26]);
      end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_vec[k] !== {1'b1, 26'h0}) begin
        errors++;
        $display("FAIL ready_rise dut%0d: got %h expected %h", k, d_vec[k], {1'b1, 26'h0});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_pulse_width();
    test_overflow();
    test_out_of_range();
    test_random();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoded_event_decoder.md
# encoded_event_decoder

Sequential counterpart of the 8-to-3 priority encoder: accepts a binary channel index with a valid/ready handshake and drives the matching one-hot output as a fixed-width pulse. Each channel also keeps a sticky pending flag, cleared by a per-channel acknowledge. The block sits downstream of the priority encoder (encoder `encoded_out`/`valid_out` → decoder `in_index`/`in_valid`) and fans events back out to per-channel consumers such as interrupt or service logic.

## Interface
- `NUM_OUTPUTS`, default 8: number of one-hot channels (2..256).
- `IDX_W`, default `$clog2(NUM_OUTPUTS)`: width of the index input.
- `PULSE_CYCLES`, default 1: cycles each one-hot pulse is held (1..16).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: index is presented.
- `in_ready`  out  1: decoder can accept an index this cycle.
- `in_index`  in  `IDX_W`: binary channel number.
- `out_onehot`  out  `NUM_OUTPUTS`: registered one-hot pulse.
- `out_valid`  out  1: high whenever `out_onehot` is nonzero.
- `pending`  out  `NUM_OUTPUTS`: sticky per-channel event flags.
- `ack`  in  `NUM_OUTPUTS`: per-channel clear for `pending`.
- `overflow`  out  `NUM_OUTPUTS`: sticky; an event hit a channel that was already pending.
- `err_index`  out  1: sticky; `in_index` ≥ `NUM_OUTPUTS` was accepted.
- `err_clear`  in  1: clears `overflow` and `err_index`.

## Operation
- FSM states: IDLE and PULSE.
- In IDLE, `in_ready` = 1.
  - A transfer occurs when `in_valid && in_ready`.
  - Index in range: on the next edge, `out_onehot` = 1 << `in_index`, the pulse counter loads `PULSE_CYCLES-1`, and the FSM goes to PULSE.
  - Index out of range: the transfer is still accepted. `err_index` is set, no output bit is driven, and the FSM stays in IDLE.
- In PULSE, `in_ready` = 0 and `out_onehot` holds its value.
  - The counter decrements each cycle.
  - When the counter is 0, the next edge clears `out_onehot` and returns the FSM to IDLE.
- Pending, per channel i, evaluated each edge:
  - An accepted in-range event for i sets `pending[i]`.
  - Otherwise `ack[i]` clears `pending[i]`.
  - If the event and `ack[i]` arrive in the same cycle, set wins.
- Overflow: `overflow[i]` is set when an event for i is accepted while `pending[i]` = 1 and `ack[i]` = 0. An event arriving together with `ack[i]` is not an overflow.
- `err_clear`: clears both sticky error outputs. If an error condition occurs in the same cycle as `err_clear`, the set wins.
- `ack` has no effect on `out_onehot`.
- Multiple `ack` bits may be high at once; each channel is independent.

## Timing
- Reset values: FSM = IDLE; `in_ready`, `out_onehot`, `out_valid`, `pending`, `overflow`, `err_index` all 0. Reset takes effect asynchronously, including mid-pulse.
- `in_ready` is held at 0 while `rst` = 1 and rises on the first edge after deassertion.
- `in_ready` is combinational from the FSM state only; it never depends on `in_valid`.
- Latency:
  - Accept edge to `out_onehot` valid: 1 cycle.
  - Pulse width: exactly `PULSE_CYCLES` cycles.
  - `pending` updates on the same edge that `out_onehot` rises.
- Throughput: one in-range event per `PULSE_CYCLES+1` cycles. Out-of-range events can be accepted every cycle.
- `ack` to `pending` clear: 1 cycle.
- All outputs except `in_ready` are registered.

## Structure
- Package `encoded_event_decoder_pkg`: the state enum (IDLE, PULSE) and a width-check constant for the pulse counter (`$clog2(PULSE_CYCLES)` rounded up, minimum 1).
- Sub-module `pending_flag_bank`: holds the pending and overflow flag registers. Inputs: set vector, `ack`, `err_clear`. Outputs: `pending`, `overflow`.
- The top level holds the FSM, the pulse counter, the decode logic, and `err_index`.

## Test plan
- Reset, then `in_index`=5, `in_valid`=1 for one cycle, `PULSE_CYCLES`=1 → next cycle `out_onehot`=8'b0010_0000, `out_valid`=1, `pending`=8'h20, `in_ready`=0. Following cycle: `out_onehot`=0 and `in_ready`=1.
- Sweep indices 0..7 with back-to-back `in_valid` held high → each one-hot bit appears exactly once in order, one accept every 2 cycles, `pending`=8'hFF at the end, `overflow`=0.
- `PULSE_CYCLES`=3, index 2 → `out_onehot`=8'h04 for exactly 3 cycles, `in_ready` low for those 3 cycles.
- Event on 3 with `pending[3]` already set and `ack[3]`=0 → `overflow[3]`=1. Repeat with `ack[3]`=1 in the same cycle → `pending[3]` stays 1 and no new overflow. Then `err_clear` → `overflow`=0.
- `NUM_OUTPUTS`=6, `in_index`=7 → accepted, `err_index`=1, `out_onehot`=0, FSM stays IDLE.
- Assert `rst` in the middle of a 4-cycle pulse → `out_onehot`, `pending` and `overflow` go to 0 immediately, without waiting for a clock edge. `in_ready` rises on the first edge after `rst` falls.
